// File: rtl/ai_accel_pkg.sv
// rtl/ai_accel_pkg.sv - shared constants and FSM encoding for the accelerator blocks
package ai_accel_pkg;

  localparam int TYPE_BW = 16;
  localparam int MAX_DIM = 16;

  localparam logic [3:0] OP_MATMUL = 4'd1;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate with clear and saturated narrow output
module mac_unit #(
  parameter int TYPE_BW = 16,
  parameter int ACC_BW  = 36
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic signed [TYPE_BW-1:0] a,
  input  logic signed [TYPE_BW-1:0] b,
  output logic signed [TYPE_BW-1:0] sat
);

  localparam logic signed [ACC_BW-1:0] MAX_V = {{(ACC_BW-TYPE_BW+1){1'b0}}, {(TYPE_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] MIN_V = {{(ACC_BW-TYPE_BW+1){1'b1}}, {(TYPE_BW-1){1'b0}}};

  logic signed [2*TYPE_BW-1:0] prod;
  logic signed [ACC_BW-1:0]    acc;

  assign prod = (2*TYPE_BW)'(a) * (2*TYPE_BW)'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_BW'(prod);
    end
  end

  // Clamp the wide sum into the element range before it leaves the unit.
  always_comb begin
    sat = acc[TYPE_BW-1:0];
    if (acc > MAX_V) begin
      sat = MAX_V[TYPE_BW-1:0];
    end else if (acc < MIN_V) begin
      sat = MIN_V[TYPE_BW-1:0];
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - sequential C = A x B engine over a packed row-major word memory
module matmul_engine #(
  parameter int TYPE_BW = ai_accel_pkg::TYPE_BW,
  parameter int MAX_DIM = ai_accel_pkg::MAX_DIM,
  parameter int AW      = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [3:0]         op_i,
  input  logic [4:0]         w_a_i,
  input  logic [4:0]         h_a_i,
  input  logic [4:0]         w_b_i,
  input  logic [4:0]         h_b_i,
  output logic               rd_en_o,
  output logic [AW-1:0]      rd_addr_o,
  input  logic [TYPE_BW-1:0] rd_data_i,
  output logic               wr_en_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [TYPE_BW-1:0] wr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  import ai_accel_pkg::*;

  localparam int ACC_BW = 2*TYPE_BW + $clog2(MAX_DIM);

  state_t state, nxt;

  logic [4:0]         w_a, h_a, w_b;
  logic [4:0]         i, j, k;
  logic [AW-1:0]      b_base, c_base;
  logic [AW-1:0]      a_addr, b_addr, c_addr;
  logic [AW-1:0]      rd_addr_q, wr_addr_q;
  logic [TYPE_BW-1:0] a_q, wr_data_q, sat;
  logic               err_q, accept, start_ok;
  logic               k_last, j_last, i_last;

  assign accept   = start_i && (state == IDLE);
  assign start_ok = (op_i == OP_MATMUL) && (w_a_i == h_b_i)
                 && (w_a_i != 5'd0) && (h_a_i != 5'd0) && (w_b_i != 5'd0) && (h_b_i != 5'd0)
                 && (int'(w_a_i) <= MAX_DIM) && (int'(h_a_i) <= MAX_DIM)
                 && (int'(w_b_i) <= MAX_DIM) && (int'(h_b_i) <= MAX_DIM);

  assign k_last = (k == w_a - 5'd1);
  assign j_last = (j == w_b - 5'd1);
  assign i_last = (i == h_a - 5'd1);

  assign a_addr = AW'(i) * AW'(w_a) + AW'(k);
  assign b_addr = b_base + AW'(k) * AW'(w_b) + AW'(j);
  assign c_addr = c_base + AW'(i) * AW'(w_b) + AW'(j);

  // Live address/data while the strobe is up, otherwise the last value driven.
  assign rd_en_o   = (state == RD_A) || (state == RD_B);
  assign rd_addr_o = (state == RD_A) ? a_addr : (state == RD_B) ? b_addr : rd_addr_q;
  assign wr_en_o   = (state == WR);
  assign wr_addr_o = wr_en_o ? c_addr : wr_addr_q;
  assign wr_data_o = wr_en_o ? sat : wr_data_q;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign err_o     = err_q;

  mac_unit #(
    .TYPE_BW (TYPE_BW),
    .ACC_BW  (ACC_BW)
  ) u_mac (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .en    (state == MAC),
    .clr   (state == WR),
    .a     (a_q),
    .b     (rd_data_i),
    .sat   (sat)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && start_ok) nxt = RD_A;
      RD_A:    nxt = RD_B;
      RD_B:    nxt = MAC;
      MAC:     nxt = k_last ? WR : RD_A;
      WR:      nxt = (i_last && j_last) ? DONE : RD_A;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      w_a       <= '0;
      h_a       <= '0;
      w_b       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      b_base    <= '0;
      c_base    <= '0;
      a_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state <= nxt;
      err_q <= accept && !start_ok;
      case (state)
        IDLE: begin
          if (accept && start_ok) begin
            w_a    <= w_a_i;
            h_a    <= h_a_i;
            w_b    <= w_b_i;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            b_base <= AW'(h_a_i) * AW'(w_a_i);
            c_base <= AW'(h_a_i) * AW'(w_a_i) + AW'(h_b_i) * AW'(w_b_i);
          end
        end
        RD_A: rd_addr_q <= a_addr;
        RD_B: begin
          a_q       <= rd_data_i;
          rd_addr_q <= b_addr;
        end
        MAC: if (!k_last) k <= k + 5'd1;
        WR: begin
          wr_addr_q <= c_addr;
          wr_data_q <= sat;
          k         <= '0;
          if (j_last) begin
            j <= '0;
            i <= i + 5'd1;
          end else begin
            j <= j + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - scoreboard bench for matmul_engine
module tb_matmul_engine;

  localparam int TYPE_BW = 16;
  localparam int MAX_DIM = 16;
  localparam int AW      = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         op = '0;
  logic [4:0]         w_a = '0, h_a = '0, w_b = '0, h_b = '0;
  logic               rd_en, wr_en, busy, done, err;
  logic [AW-1:0]      rd_addr, wr_addr;
  logic [TYPE_BW-1:0] rd_data = '0;
  logic [TYPE_BW-1:0] wr_data;

  logic signed [TYPE_BW-1:0] mem [0:(1<<AW)-1];

  typedef struct packed {
    logic [AW-1:0]      addr;
    logic [TYPE_BW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  n_wr = 0;
  int  n_rd = 0;
  int  n_done = 0;

  matmul_engine #(.TYPE_BW(TYPE_BW), .MAX_DIM(MAX_DIM), .AW(AW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .start_i   (start),
    .op_i      (op),
    .w_a_i     (w_a),
    .h_a_i     (h_a),
    .w_b_i     (w_b),
    .h_b_i     (h_b),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Scoreboard: each DUT write pops the oldest expected write.
  always @(negedge clk) begin
    if (rd_en) n_rd++;
    if (done) n_done++;
    if (wr_en) begin
      wr_t e;
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%0d", wr_addr, $signed(wr_data));
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_fail++;
          $display("FAIL write_check got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   wr_addr, $signed(wr_data), e.addr, $signed(e.data));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int n_cycles(input int wa, input int ha, input int wb);
    return ha * wb * (3 * wa + 1);
  endfunction

  task automatic load(input int addr, input int v);
    mem[addr] = 16'(v);
  endtask

  task automatic expect_wr(input int addr, input int v);
    wr_t e;
    e.addr = AW'(addr);
    e.data = 16'(v);
    exp_q.push_back(e);
  endtask

  // Independent reference: full-precision sum, then clamp.
  task automatic push_model(input int wa, input int ha, input int wb);
    int bb, cb;
    longint acc;
    bb = ha * wa;
    cb = bb + wa * wb;
    for (int ii = 0; ii < ha; ii++) begin
      for (int jj = 0; jj < wb; jj++) begin
        acc = 0;
        for (int kk = 0; kk < wa; kk++)
          acc += longint'(mem[ii*wa+kk]) * longint'(mem[bb+kk*wb+jj]);
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        expect_wr(cb + ii*wb + jj, int'(acc));
      end
    end
  endtask

  task automatic do_start(input logic [3:0] o, input int wa, input int ha, input int wb, input int hb);
    @(negedge clk);
    op = o; w_a = 5'(wa); h_a = 5'(ha); w_b = 5'(wb); h_b = 5'(hb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int limit, output int t);
    t = t0;
    while (done !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, rd_en, wr_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b expected 00000", {busy, done, err, rd_en, wr_en});
    end
    n_cmp++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses got rd_addr=%0d wr_addr=%0d wr_data=%0d expected 0", rd_addr, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_square;
    int t, rd0;
    load(0, -3); load(1, -15); load(2, -6); load(3, 7);
    load(4, 9);  load(5, -15); load(6, -2); load(7, -5);
    expect_wr(8, 3); expect_wr(9, 120); expect_wr(10, -68); expect_wr(11, 55);
    rd0 = n_rd;
    do_start(4'd1, 2, 2, 2, 2);
    wait_done(1, 100, t);
    n_cmp++;
    if (done !== 1'b1 || t != 29) begin
      n_fail++;
      $display("FAIL square_done_cycle got %0d expected 29", t);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL square_after_done got done=%b busy=%b expected 0 0", done, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0 || n_rd - rd0 != 16) begin
      n_fail++;
      $display("FAIL square_counts got pending=%0d reads=%0d expected 0 16", exp_q.size(), n_rd - rd0);
    end
  endtask

  task automatic test_nonsquare;
    int t;
    load(0, 1); load(1, 2); load(2, 3); load(3, 4); load(4, 5);
    expect_wr(5, 4); expect_wr(6, 5); expect_wr(7, 8);
    expect_wr(8, 10); expect_wr(9, 12); expect_wr(10, 15);
    do_start(4'd1, 1, 3, 2, 1);
    wait_done(1, 100, t);
    n_cmp++;
    if (done !== 1'b1 || t != 25) begin
      n_fail++;
      $display("FAIL nonsquare_done_cycle got %0d expected 25", t);
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL nonsquare_pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_saturation;
    int t;
    int av[2] = '{32767, -32768};
    int bv[2] = '{2, 3};
    int ev[2] = '{32767, -32768};
    for (int c = 0; c < 2; c++) begin
      load(0, av[c]); load(1, bv[c]);
      expect_wr(2, ev[c]);
      do_start(4'd1, 1, 1, 1, 1);
      wait_done(1, 50, t);
      n_cmp++;
      if (done !== 1'b1 || t != 5) begin
        n_fail++;
        $display("FAIL sat_done_cycle case=%0d got %0d expected 5", c, t);
      end
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL sat_pending case=%0d got %0d expected 0", c, exp_q.size());
      end
    end
  endtask

  task automatic test_reject;
    int ops[3] = '{1, 2, 1};
    int was[3] = '{2, 2, 0};
    int hbs[3] = '{3, 2, 0};
    int rd0, wr0;
    logic bus;
    for (int c = 0; c < 3; c++) begin
      rd0 = n_rd;
      wr0 = n_wr;
      do_start(4'(ops[c]), was[c], 2, 2, hbs[c]);
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_err case=%0d got err=%b busy=%b expected 1 0", c, err, busy);
      end
      bus = 1'b0;
      repeat (5) begin
        @(negedge clk);
        bus = bus | busy | rd_en | wr_en | err;
      end
      n_cmp++;
      if (bus !== 1'b0 || n_rd != rd0 || n_wr != wr0) begin
        n_fail++;
        $display("FAIL reject_quiet case=%0d got activity=%b reads=%0d writes=%0d expected 0 0 0",
                 c, bus, n_rd - rd0, n_wr - wr0);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t, wr0, done0;
    load(0, -3); load(1, -15); load(2, -6); load(3, 7);
    load(4, 9);  load(5, -15); load(6, -2); load(7, -5);
    expect_wr(8, 3); expect_wr(9, 120); expect_wr(10, -68); expect_wr(11, 55);
    wr0 = n_wr;
    done0 = n_done;
    do_start(4'd1, 2, 2, 2, 2);
    t = 1;
    while (t < 10) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs got busy=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0d expected all 0",
               busy, rd_en, wr_en, rd_addr, wr_addr, wr_data);
    end
    exp_q.delete();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_wr - wr0 != 1 || n_done != done0) begin
      n_fail++;
      $display("FAIL abort_activity got writes=%0d dones=%0d expected 1 0", n_wr - wr0, n_done - done0);
    end
    rst_n = 1'b1;
    expect_wr(8, 3); expect_wr(9, 120); expect_wr(10, -68); expect_wr(11, 55);
    do_start(4'd1, 2, 2, 2, 2);
    wait_done(1, 100, t);
    n_cmp++;
    if (done !== 1'b1 || t != 29) begin
      n_fail++;
      $display("FAIL rerun_done_cycle got %0d expected 29", t);
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rerun_pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int t, wr0, done0;
    expect_wr(8, 3); expect_wr(9, 120); expect_wr(10, -68); expect_wr(11, 55);
    wr0 = n_wr;
    done0 = n_done;
    do_start(4'd1, 2, 2, 2, 2);
    t = 1;
    while (t < 5) begin
      @(negedge clk);
      t++;
    end
    op = 4'd1; w_a = 5'd1; h_a = 5'd1; w_b = 5'd1; h_b = 5'd1;
    start = 1'b1;
    @(negedge clk);
    t++;
    start = 1'b0;
    wait_done(t, 100, t);
    n_cmp++;
    if (done !== 1'b1 || t != 29) begin
      n_fail++;
      $display("FAIL busy_start_done_cycle got %0d expected 29", t);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (n_wr - wr0 != 4 || n_done - done0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_counts got writes=%0d dones=%0d busy=%b expected 4 1 0",
               n_wr - wr0, n_done - done0, busy);
    end
  endtask

  task automatic test_random;
    int t, wa, ha, wb, n;
    for (int it = 0; it < 4; it++) begin
      wa = $urandom_range(1, 4);
      ha = $urandom_range(1, 4);
      wb = $urandom_range(1, 4);
      for (int a = 0; a < ha*wa + wa*wb; a++)
        load(a, (it < 2) ? ($urandom_range(0, 200) - 100) : int'($signed(16'($urandom))));
      push_model(wa, ha, wb);
      n = n_cycles(wa, ha, wb);
      do_start(4'd1, wa, ha, wb, wa);
      wait_done(1, 300, t);
      n_cmp++;
      if (done !== 1'b1 || t != n + 1) begin
        n_fail++;
        $display("FAIL random_done_cycle it=%0d got %0d expected %0d", it, t, n + 1);
      end
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL random_pending it=%0d got %0d expected 0", it, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_nonsquare();
    test_saturation();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter TYPE_BW, default 16: signed element width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 16: largest permitted matrix dimension.
REQ-003 SHALL have parameter AW, default 10: word-address width of the matrix memory.
REQ-004 SHALL have port wb_clk_i, input, 1: the single clock, rising-edge.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1: single-cycle start request.
REQ-007 SHALL have port op_i, input, 4: operation code; 1 = matrix multiply.
REQ-008 SHALL have ports w_a_i, h_a_i, w_b_i, h_b_i, input, 5 each: matrix dimensions.
REQ-009 SHALL have ports rd_en_o (output, 1), rd_addr_o (output, AW) and rd_data_i (input, TYPE_BW): memory read port with 1-cycle latency.
REQ-010 SHALL have ports wr_en_o (output, 1), wr_addr_o (output, AW) and wr_data_o (output, TYPE_BW): memory write port.
REQ-011 SHALL have port busy_o, output, 1: an operation is in progress.
REQ-012 SHALL have ports done_o and err_o, output, 1 each: single-cycle completion pulse and single-cycle error pulse.

Function
REQ-013 SHALL sample op_i and all four dimensions on the cycle start_i is high in IDLE, and hold them internally until the operation ends.
REQ-014 SHALL reject a start (err_o pulses 1 cycle later; no reads, no writes; stays IDLE) if any of these hold: op_i != 1; w_a != h_b; any dimension is 0; any dimension > MAX_DIM.
REQ-015 SHALL ignore start_i while busy_o=1.
REQ-016 SHALL use a packed row-major layout, in word addresses: A_base=0, B_base=h_a*w_a, C_base=B_base+h_b*w_b; element A[i][k] is at A_base+i*w_a+k, B[k][j] at B_base+k*w_b+j, C[i][j] at C_base+i*w_b+j.
REQ-017 SHALL implement FSM states IDLE, RD_A, RD_B, MAC, WR, DONE.
REQ-018 SHALL sequence the FSM as follows:
  - IDLE->RD_A on a valid start.
  - RD_A: issue read of A[i][k].
  - RD_B: capture A data; issue read of B[k][j].
  - MAC: capture B data; acc += A*B.
  - MAC->RD_A if k < w_a-1, else ->WR.
  - WR: write C[i][j], clear acc, advance j then i.
  - WR->RD_A while elements remain, else ->DONE.
  - DONE: pulse done_o, then ->IDLE.
REQ-019 SHALL compute C in the order i outer, j inner, k innermost.
REQ-020 SHALL produce the product as a full 2*TYPE_BW signed value and accumulate it in a signed accumulator of 2*TYPE_BW+$clog2(MAX_DIM) bits.
REQ-021 SHALL write wr_data_o as the accumulator saturated to the signed TYPE_BW range.
REQ-022 SHALL assert rd_en_o only in RD_A and RD_B, and wr_en_o only in WR, each for exactly one cycle per access.
REQ-023 SHALL drive busy_o high from the cycle after a valid start through the DONE cycle inclusive.
REQ-024 SHALL pulse done_o exactly N+1 cycles after the start cycle, where N=h_a*w_b*(3*w_a+1).
REQ-025 SHALL hold rd_addr_o, wr_addr_o and wr_data_o stable at their last values while the corresponding enable is low.

Reset
REQ-026 SHALL, while wb_rst_i=0, force the FSM to IDLE and hold at 0: busy_o, done_o, err_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_data_o, the accumulator and all indices.
REQ-027 SHALL, when reset is asserted mid-operation, abort at once, issue no further reads or writes, and produce no done_o pulse.

Structure
REQ-028 SHALL place the following in a shared package ai_accel_pkg: TYPE_BW, MAX_DIM, the opcode constant OP_MATMUL=1, and the FSM state enumeration.
REQ-029 SHALL contain one sub-module, mac_unit: a signed multiply, accumulate and clear unit with a saturating output.

Verification
REQ-030 SHALL test the 2x2 case:
  - Stimulus: A=[-3 -15; -6 7], B=[9 -15; -2 -5], all dimensions 2.
  - Response: writes at addresses 8,9,10,11 with data 3, 120, -68, 55.
  - Response: done_o exactly 29 cycles after start.
REQ-031 SHALL test a non-square case:
  - Stimulus: A is 3x1 = [1;2;3], B is 1x2 = [4 5].
  - Response: C written at addresses 5..10 as 4,5,8,10,12,15.
  - Response: done_o at cycle 25.
REQ-032 SHALL test saturation:
  - Stimulus: 1x1 matrices, A=[32767], B=[2] (TYPE_BW=16).
  - Response: write of 32767 at address 2.
REQ-033 SHALL test rejection:
  - Stimulus: w_a=2, h_b=3; then, separately, op_i=2; then, separately, a dimension of 0.
  - Response: each produces an err_o pulse, no rd_en_o or wr_en_o, and busy_o stays 0.
REQ-034 SHALL test reset mid-operation:
  - Stimulus: start a 2x2 operation, then assert wb_rst_i=0 at cycle 10.
  - Response: all outputs are 0 at once, there is no write after cycle 10, and no done_o pulse occurs.
  - Response: a following start runs normally.
REQ-035 SHALL test start while busy:
  - Stimulus: a second start_i pulse during a 2x2 operation.
  - Response: the pulse is ignored; exactly 4 writes occur and exactly one done_o pulse.
